// File: rtl/sobel_win_fetch.sv
// rtl/sobel_win_fetch.sv - Sobel read-side controller: walks interior pixels and
// fetches each 3x3 neighbourhood over two BRAM read ports into a valid/ready window.
module sobel_win_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   addr0,
  output logic [ADDR_WIDTH-1:0]   addr1,
  output logic                    ce0,
  output logic                    ce1,
  output logic                    we0,
  output logic                    we1,
  input  logic [DATA_WIDTH-1:0]   q0,
  input  logic [DATA_WIDTH-1:0]   q1,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic [ADDR_WIDTH-1:0]   win_x,
  output logic [ADDR_WIDTH-1:0]   win_y,
  output logic                    win_valid,
  input  logic                    win_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CAP   = 3'd2,
    S_VALID = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] W_A    = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(IMG_W - 2);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(IMG_H - 2);
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO_A  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] THREE_A = ADDR_WIDTH'(3);

  state_t                  state_q, state_d;
  logic [2:0]              k_q, k_d;
  logic [ADDR_WIDTH-1:0]   x_q, x_d;
  logic [ADDR_WIDTH-1:0]   y_q, y_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
  logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d;
  logic                    ce0_q, ce0_d;
  logic                    ce1_q, ce1_d;
  logic [DATA_WIDTH-1:0]   win_q [0:8];
  logic [DATA_WIDTH-1:0]   win_d [0:8];
  logic                    cap_en;
  logic [2:0]              cap_k;

  // base is the top-left (x-1, y-1) address; element (r,c) sits at base + r*IMG_W + c.
  function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [3:0]            e);
    logic [ADDR_WIDTH-1:0] row_off;
    logic [ADDR_WIDTH-1:0] col_off;
    case (e)
      4'd0, 4'd1, 4'd2: row_off = '0;
      4'd3, 4'd4, 4'd5: row_off = W_A;
      default:          row_off = W_A + W_A;
    endcase
    case (e)
      4'd0, 4'd3, 4'd6: col_off = '0;
      4'd1, 4'd4, 4'd7: col_off = ONE_A;
      default:          col_off = TWO_A;
    endcase
    return base + row_off + col_off;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          k_d     = 3'd0;
          x_d     = ONE_A;
          y_d     = ONE_A;
          base_d  = '0;
        end
      end
      S_RD: begin
        if (k_q == 3'd4) begin
          state_d = S_CAP;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_CAP: begin
        state_d = S_VALID;
      end
      S_VALID: begin
        if (win_ready) begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            k_d     = 3'd0;
            // Wrapping to the next row skips the two border columns: top-left moves by 3.
            if (x_q == X_LAST) begin
              x_d    = ONE_A;
              y_d    = y_q + ONE_A;
              base_d = base_q + THREE_A;
            end else begin
              x_d    = x_q + ONE_A;
              base_d = base_q + ONE_A;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read strobes are registered, so they are computed from the next-cycle step.
  always_comb begin
    ce0_d   = (state_d == S_RD);
    ce1_d   = (state_d == S_RD) && (k_d != 3'd4);
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    if (state_d == S_RD) begin
      addr0_d = elem_addr(base_d, {k_d, 1'b0});
      if (k_d != 3'd4) begin
        addr1_d = elem_addr(base_d, {k_d, 1'b1});
      end
    end
  end

  // Data for issue step k arrives one cycle later: during RD k+1, or CAP for step 4.
  always_comb begin
    cap_en = (state_q == S_CAP) || (state_q == S_RD && k_q != 3'd0);
    cap_k  = (state_q == S_CAP) ? 3'd4 : (k_q - 3'd1);
    for (int e = 0; e < 9; e++) begin
      win_d[e] = win_q[e];
    end
    if (cap_en) begin
      win_d[{cap_k, 1'b0}] = q0;
      if (cap_k != 3'd4) begin
        win_d[{cap_k, 1'b1}] = q1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      ce0_q   <= 1'b0;
      ce1_q   <= 1'b0;
      for (int e = 0; e < 9; e++) begin
        win_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      ce0_q   <= ce0_d;
      ce1_q   <= ce1_d;
      for (int e = 0; e < 9; e++) begin
        win_q[e] <= win_d[e];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int e = 0; e < 9; e++) begin
      win_data[e*DATA_WIDTH +: DATA_WIDTH] = win_q[e];
    end
  end

  assign busy      = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_VALID);
  assign done      = (state_q == S_DONE);
  assign win_valid = (state_q == S_VALID);
  assign win_x     = x_q;
  assign win_y     = y_q;
  assign addr0     = addr0_q;
  assign addr1     = addr1_q;
  assign ce0       = ce0_q;
  assign ce1       = ce1_q;
  assign we0       = 1'b0;
  assign we1       = 1'b0;

endmodule

// File: tb/tb_sobel_win_fetch.sv
// tb/tb_sobel_win_fetch.sv - self-checking bench for sobel_win_fetch (4x4 and 5x3 images)
module tb_sobel_win_fetch;
  localparam int DW = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           busy, done, ce0, ce1, we0, we1, win_valid;
  logic           win_ready = 1'b0;
  logic [AW-1:0]  addr0, addr1, win_x, win_y;
  logic [DW-1:0]  q0 = '0, q1 = '0;
  logic [9*DW-1:0] win_data;

  logic           start_b = 1'b0;
  logic           busy_b, done_b, ce0_b, ce1_b, we0_b, we1_b, win_valid_b;
  logic           win_ready_b = 1'b0;
  logic [AW-1:0]  addr0_b, addr1_b, win_x_b, win_y_b;
  logic [DW-1:0]  q0_b = '0, q1_b = '0;
  logic [9*DW-1:0] win_data_b;

  sobel_win_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .addr0(addr0), .addr1(addr1), .ce0(ce0), .ce1(ce1), .we0(we0), .we1(we1),
    .q0(q0), .q1(q1), .win_data(win_data), .win_x(win_x), .win_y(win_y),
    .win_valid(win_valid), .win_ready(win_ready)
  );

  sobel_win_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(5), .IMG_H(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .addr0(addr0_b), .addr1(addr1_b), .ce0(ce0_b), .ce1(ce1_b), .we0(we0_b), .we1(we1_b),
    .q0(q0_b), .q1(q1_b), .win_data(win_data_b), .win_x(win_x_b), .win_y(win_y_b),
    .win_valid(win_valid_b), .win_ready(win_ready_b)
  );

  logic [7:0] ram [0:15];

  always @(posedge clk) begin
    if (ce0) q0 <= ram[addr0[3:0]];
    if (ce1) q1 <= ram[addr1[3:0]];
    if (ce0_b) q0_b <= addr0_b[7:0];
    if (ce1_b) q1_b <= addr1_b[7:0];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    logic [71:0] w;
    w = {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return w;
  endfunction

  // Reference window n of the 4x4 frame, read straight from the image array.
  function automatic logic [71:0] model_win(input int n);
    logic [71:0] w;
    int x, y;
    x = 1 + n % 2;
    y = 1 + n / 2;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = ram[(y - 1 + r) * 4 + (x - 1 + c)];
    return w;
  endfunction

  typedef struct {
    int          cyc;
    logic        ce0, ce1;
    logic        chk_a0, chk_a1;
    logic [15:0] a0, a1;
    logic        valid, busy, done;
  } vec_t;

  vec_t tbl [8];

  function automatic vec_t mk(input int cyc, input logic c0, c1, k0, k1, input int a0, a1,
                              input logic v, b, d);
    vec_t t;
    t.cyc = cyc; t.ce0 = c0; t.ce1 = c1; t.chk_a0 = k0; t.chk_a1 = k1;
    t.a0 = 16'(a0); t.a1 = 16'(a1); t.valid = v; t.busy = b; t.done = d;
    return t;
  endfunction

  task automatic run_frame(input int mode, input int extra_start, input bit use_tbl,
                           output int done_cyc, output int nwin);
    int cyc, stall_left, last_hs;
    logic rdy, prev_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; nwin = 0; done_cyc = -1; stall_left = 10; last_hs = 0; prev_v = 1'b0;
    while (cyc < 3000) begin
      case (mode)
        1:       rdy = ($urandom_range(0, 2) != 0);
        2: begin
          if (win_valid && nwin == 1 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end else rdy = 1'b1;
        end
        default: rdy = 1'b1;
      endcase
      win_ready = rdy;
      if (use_tbl) begin
        for (int i = 0; i < 8; i++) begin
          if (tbl[i].cyc == cyc) begin
            check($sformatf("tbl_ce c%0d", cyc), {ce0, ce1}, {tbl[i].ce0, tbl[i].ce1});
            if (tbl[i].chk_a0) check($sformatf("tbl_addr0 c%0d", cyc), addr0, tbl[i].a0);
            if (tbl[i].chk_a1) check($sformatf("tbl_addr1 c%0d", cyc), addr1, tbl[i].a1);
            check($sformatf("tbl_vbd c%0d", cyc), {win_valid, busy, done},
                  {tbl[i].valid, tbl[i].busy, tbl[i].done});
          end
        end
      end
      check("we_zero", {we0, we1}, 2'b00);
      if (win_valid) begin
        check("no_ce_in_valid", {ce0, ce1}, 2'b00);
        if (!prev_v)
          check($sformatf("valid_start w%0d", nwin), cyc, (nwin == 0) ? 7 : last_hs + 7);
        check($sformatf("win_data w%0d", nwin), win_data, model_win(nwin));
        check($sformatf("win_x w%0d", nwin), win_x, 1 + nwin % 2);
        check($sformatf("win_y w%0d", nwin), win_y, 1 + nwin / 2);
        if (use_tbl && nwin == 0) check("win11_const", win_data, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        if (mode == 2 && nwin == 1) check("win21_const", win_data, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        if (rdy) begin
          nwin++;
          last_hs = cyc;
        end
      end
      prev_v = win_valid && !rdy;
      if (done) begin
        done_cyc = cyc;
        check("busy_at_done", busy, 1'b0);
        break;
      end
      if (cyc == extra_start) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (done_cyc < 0) check("frame_timeout", 1'b1, 1'b0);
    check("win_count", nwin, 4);
    @(posedge clk); #1;
    check("idle_after_done", {busy, done, win_valid}, 3'b000);
  endtask

  int dc, nw;

  initial begin
    tbl[0] = mk(1, 1, 1, 1, 1, 0, 1, 0, 1, 0);
    tbl[1] = mk(2, 1, 1, 1, 1, 2, 4, 0, 1, 0);
    tbl[2] = mk(3, 1, 1, 1, 1, 5, 6, 0, 1, 0);
    tbl[3] = mk(4, 1, 1, 1, 1, 8, 9, 0, 1, 0);
    tbl[4] = mk(5, 1, 0, 1, 0, 10, 0, 0, 1, 0);
    tbl[5] = mk(6, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[6] = mk(7, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[7] = mk(29, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int a = 0; a < 16; a++) ram[a] = 8'(a);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, win_valid, ce0, ce1, we0, we1}, 7'b0);
    check("rst_addr", {addr0, addr1}, 32'b0);
    check("rst_win", {win_data, win_x, win_y}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_frame(0, -1, 1'b1, dc, nw);
    check("done_cyc_basic", dc, 29);
    run_frame(0, 3, 1'b1, dc, nw);
    check("done_cyc_start_busy", dc, 29);
    run_frame(2, -1, 1'b0, dc, nw);
    check("done_cyc_stall", dc, 39);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_ctrl", {busy, done, win_valid, ce0, ce1, we0, we1}, 7'b0);
    check("midrst_addr", {addr0, addr1}, 32'b0);
    check("midrst_win", {win_data, win_x, win_y}, '0);
    @(posedge clk); #1;
    check("midrst_idle", {busy, ce0, ce1}, 3'b000);
    run_frame(0, -1, 1'b1, dc, nw);
    check("done_cyc_after_rst", dc, 29);

    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < 16; a++) ram[a] = 8'($urandom);
      run_frame(1, -1, 1'b0, dc, nw);
    end

    begin
      int cyc, nb;
      logic [71:0] exp_w;
      bit seen_done;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      win_ready_b = 1'b1;
      cyc = 1; nb = 0; seen_done = 1'b0;
      while (cyc < 200 && !seen_done) begin
        if (win_valid_b) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              exp_w[(r*3+c)*8 +: 8] = 8'(r * 5 + nb + c);
          check($sformatf("b_win_data w%0d", nb), win_data_b, exp_w);
          check($sformatf("b_win_xy w%0d", nb), {win_x_b, win_y_b}, {16'(nb + 1), 16'd1});
          if (nb == 2) check("b_win3_const", win_data_b, pack9(2, 3, 4, 7, 8, 9, 12, 13, 14));
          nb++;
        end
        if (done_b) begin
          seen_done = 1'b1;
          check("b_done_cyc", cyc, 22);
          check("b_win_count", nb, 3);
        end else begin
          @(posedge clk); #1;
          cyc++;
        end
      end
      if (!seen_done) check("b_timeout", 1'b1, 1'b0);
      win_ready_b = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
